stream_to_axi4_wr_burst: RTL and testbench

STREAM_TO_AXI4_WR_BURST -- requirements
Module: stream_to_axi4_wr_burst

---
 rtl/stream_to_axi4_wr_burst.sv | 153 +++++++++++++++
 tb/tb_stream_to_axi4_wr_burst.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_axi4_wr_burst.sv
// Streams a frame of beats to memory as a series of AXI4 INCR write bursts.
// Latency: W is a zero-latency pass-through of s_data; NEXT and FIN each add one cycle per burst and frame.
// Backpressure: s_ready mirrors wready only while a burst's data phase is open; one burst outstanding at a time.
//
// Ports: clock/rst (async, active-high); start/base_addr/total_beats frame command;
//        s_data/s_valid/s_ready input stream; AXI4 write master aw*/w*/b*; busy/done/err status.
// Optional: define WR_TIMEOUT_EN to add a write-response watchdog that aborts the frame with err.
module stream_to_axi4_wr_burst #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_STEP  = 8
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [23:0]             total_beats,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, AW, WDATA, WRESP, NEXT, FIN} state_t;

  localparam int AXSIZE = $clog2(DATA_WIDTH / 8);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [23:0]             remain;
  logic [7:0]              beat_cnt;
  logic                    err_q;
  logic [7:0]              burst_m1;
  logic [8:0]              burst_beats;
  logic                    w_hs;
  logic                    to_expire;

  // Response ID is not used: only one burst is ever in flight.
  logic unused_bid;
  assign unused_bid = ^bid;

  // Length of the burst at the head of the remaining frame; remain is only
  // updated in NEXT, so this stays stable through AW, WDATA and WRESP.
  always_comb begin
    burst_m1 = 8'd0;
    if (remain >= 24'(BURST_LEN))
      burst_m1 = 8'(BURST_LEN - 1);
    else if (remain != 24'd0)
      burst_m1 = 8'(remain - 24'd1);
  end
  assign burst_beats = {1'b0, burst_m1} + 9'd1;

  assign w_hs = (state == WDATA) && s_valid && wready;

`ifdef WR_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'd1022;  // 1023rd cycle waiting in WRESP
  logic [9:0] to_cnt;

  assign to_expire = (state == WRESP) && !bvalid && (to_cnt == TO_LAST);

  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      to_cnt <= 10'd0;
    else if (state == WRESP)
      to_cnt <= to_cnt + 10'd1;
    else
      to_cnt <= 10'd0;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (total_beats != 24'd0) ? AW : FIN;
      AW:      if (awready) state_n = WDATA;
      WDATA:   if (w_hs && (beat_cnt == burst_m1)) state_n = WRESP;
      WRESP: begin
        if (bvalid)         state_n = NEXT;
        else if (to_expire) state_n = FIN;
      end
      NEXT:    state_n = (remain == 24'(burst_beats)) ? FIN : AW;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      remain   <= 24'd0;
      beat_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          addr   <= base_addr;
          remain <= total_beats;
          err_q  <= 1'b0;
        end
        AW:    beat_cnt <= 8'd0;
        WDATA: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        WRESP: if ((bvalid && (bresp != 2'b00)) || to_expire) err_q <= 1'b1;
        NEXT: begin
          remain <= remain - 24'(burst_beats);
          addr   <= addr + ADDR_WIDTH'(ADDR_STEP) * ADDR_WIDTH'(burst_beats);
        end
        // An aborted frame leaves beats behind; clear so awlen idles at 0.
        FIN:   remain <= 24'd0;
        default: ;
      endcase
    end
  end

  assign awid    = 4'd0;
  assign awburst = 2'b01;
  assign awsize  = 3'(AXSIZE);
  assign wstrb   = '1;
  assign awaddr  = addr;
  assign awlen   = burst_m1;
  assign awvalid = (state == AW);
  assign wdata   = s_data;
  assign wvalid  = (state == WDATA) && s_valid;
  assign s_ready = (state == WDATA) && wready;
  assign wlast   = (state == WDATA) && (beat_cnt == burst_m1);
  assign bready  = (state == WRESP);
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign err     = err_q;

endmodule

// File: tb/tb_stream_to_axi4_wr_burst.sv
// Randomized bench for stream_to_axi4_wr_burst against a frame-level reference model.
// Default parameters: 27-bit address, 256-bit data, 32-beat bursts, 8 address units per beat.
module tb_stream_to_axi4_wr_burst;

  logic         clock, rst, start;
  logic [26:0]  base_addr;
  logic [23:0]  total_beats;
  logic [255:0] s_data;
  logic         s_valid, s_ready;
  logic [3:0]   awid;
  logic [26:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic         busy, done, err;

  stream_to_axi4_wr_burst dut (
    .clock(clock), .rst(rst), .start(start), .base_addr(base_addr), .total_beats(total_beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Shared bench state (each variable has exactly one writer process).
  logic [255:0] stim[$];        // main: frame payload in stream order
  bit           thr;            // main: random throttling on/off
  bit           b_hold;         // main: slave never answers B
  int           berr_at;        // main: absolute B index answered with SLVERR
  int           cyc;            // cycle counter
  logic [26:0]  aw_addr_q[$];   // monitor
  logic [7:0]   aw_len_q[$];
  logic [255:0] w_dat_q[$];
  bit           w_last_q[$];
  int           wl_cnt, done_cnt, done_cyc, last_wl_cyc, viol;
  int           open_b, open_w;
  bit           w_hs_seen, b_hs_seen;
  int           src_ptr;        // source
  int           b_issued;       // slave

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin @(posedge clock); cyc++; end
  end

  // Monitor: samples on the falling edge, records handshakes and protocol breaks.
  initial begin
    wl_cnt = 0; done_cnt = 0; done_cyc = 0; last_wl_cyc = 0; viol = 0;
    open_b = 0; open_w = 0; w_hs_seen = 0; b_hs_seen = 0;
    forever begin
      @(negedge clock);
      w_hs_seen = wvalid && wready;
      b_hs_seen = bvalid && bready;
      if (rst) begin
        open_b = 0; open_w = 0;
      end else begin
        if (awvalid && open_b != 0) viol++;
        if (wvalid && open_w == 0) viol++;
        if (s_ready !== (wready && open_w != 0)) viol++;
        if (awvalid && awready) begin
          aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen);
          open_b++; open_w++;
        end
        if (wvalid && wready) begin
          w_dat_q.push_back(wdata); w_last_q.push_back(wlast);
          if (wlast) begin wl_cnt++; open_w--; last_wl_cyc = cyc; end
        end
        if (bvalid && bready) open_b--;
        if (done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  // Stream source: presents stim[src_ptr], advancing on each accepted beat.
  initial begin
    s_valid = 1'b0; s_data = '0; src_ptr = 0;
    forever begin
      @(posedge clock); #1;
      if (rst) begin
        src_ptr = stim.size(); s_valid = 1'b0;
      end else begin
        if (w_hs_seen) src_ptr++;
        if (src_ptr < stim.size()) begin
          s_valid = !thr || ($urandom_range(0, 1) == 1);
          s_data  = stim[src_ptr];
        end else s_valid = 1'b0;
      end
    end
  end

  // AXI slave: random ready throttling, one B per completed W burst.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0; b_issued = 0;
    forever begin
      @(posedge clock); #1;
      if (rst) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      end else begin
        awready = !thr || ($urandom_range(0, 1) == 1);
        wready  = !thr || ($urandom_range(0, 2) != 0);
        if (b_hs_seen) bvalid = 1'b0;
        if (!bvalid && wl_cnt > b_issued && !b_hold && (!thr || $urandom_range(0, 1) == 1)) begin
          bvalid = 1'b1;
          bresp  = (b_issued == berr_at) ? 2'b10 : 2'b00;
          b_issued++;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_awvalid"}, awvalid, 1'b0);
    chk({pfx, "_wvalid"},  wvalid,  1'b0);
    chk({pfx, "_wlast"},   wlast,   1'b0);
    chk({pfx, "_bready"},  bready,  1'b0);
    chk({pfx, "_s_ready"}, s_ready, 1'b0);
    chk({pfx, "_busy"},    busy,    1'b0);
    chk({pfx, "_done"},    done,    1'b0);
    chk({pfx, "_err"},     err,     1'b0);
    chk({pfx, "_awaddr"},  awaddr,  27'd0);
    chk({pfx, "_awlen"},   awlen,   8'd0);
  endtask

  task automatic pulse_start(input logic [26:0] base, input int total);
    @(posedge clock); #1;
    base_addr = base; total_beats = 24'(total); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // One frame: builds the expected burst list from plain arithmetic, then compares.
  task automatic run_frame(input logic [26:0] base, input int total, input bit throttle,
                           input int berr_k, input bit exp_err);
    int aw0, w0, d0, st0, s_cyc, t, r, len, nexp;
    logic [26:0] a;
    logic [26:0] ea[$];
    logic [7:0]  el[$];
    bit          elast[$];
    aw0 = aw_addr_q.size(); w0 = w_dat_q.size(); d0 = done_cnt; st0 = stim.size();
    for (int i = 0; i < total; i++) stim.push_back(rand256());
    thr = throttle;
    berr_at = (berr_k < 0) ? -1 : b_issued + berr_k;
    pulse_start(base, total);
    s_cyc = cyc - 1;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(negedge clock); t++; end
    if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
    r = total; a = base;
    while (r > 0) begin
      len = (r < 32) ? r : 32;
      ea.push_back(a); el.push_back(8'(len - 1));
      for (int j = 0; j < len; j++) elast.push_back(j == len - 1);
      a = a + 27'(len * 8);
      r -= len;
    end
    chk("aw_count", aw_addr_q.size() - aw0, ea.size());
    nexp = (aw_addr_q.size() - aw0 < ea.size()) ? aw_addr_q.size() - aw0 : ea.size();
    for (int k = 0; k < nexp; k++) begin
      chk("awaddr", aw_addr_q[aw0 + k], ea[k]);
      chk("awlen",  aw_len_q[aw0 + k],  el[k]);
    end
    chk("w_count", w_dat_q.size() - w0, total);
    nexp = (w_dat_q.size() - w0 < total) ? w_dat_q.size() - w0 : total;
    for (int k = 0; k < nexp; k++) begin
      chk("wdata", w_dat_q[w0 + k], stim[st0 + k]);
      chk("wlast", w_last_q[w0 + k], elast[k]);
    end
    if (total == 0) chk("zero_done_latency_ok", (done_cyc - s_cyc >= 1) && (done_cyc - s_cyc <= 2), 1'b1);
    repeat (3) @(negedge clock);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", busy, 1'b0);
    chk("err_after", err, exp_err);
    chk("protocol_viol", viol, 0);
    chk("const_fields", {awid, awsize, awburst, wstrb}, {4'd0, 3'd5, 2'b01, 32'hFFFF_FFFF});
  endtask

  initial begin
    int tot, k, aw0, w0, t;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0;
    thr = 1'b0; b_hold = 1'b0; berr_at = -1;
    repeat (3) @(posedge clock); #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_frame(27'h100, 64, 1'b0, -1, 1'b0);
    run_frame(27'h100, 70, 1'b0, -1, 1'b0);
    run_frame(27'h040, 0,  1'b0, -1, 1'b0);
    run_frame(27'h1234, 40, 1'b1, -1, 1'b0);
    run_frame(27'h100, 64, 1'b0, 0, 1'b1);
    repeat (5) @(negedge clock);
    chk("err_hold", err, 1'b1);
    run_frame(27'h200, 5, 1'b0, -1, 1'b0);
    run_frame(27'h7FF_FF80, 70, 1'b1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tot = $urandom_range(1, 100);
      k   = $urandom_range(0, 3);
      run_frame(27'($urandom), tot, 1'b1, k, k < (tot + 31) / 32);
    end

    // Reset in the middle of the data phase of a burst.
    for (int i = 0; i < 64; i++) stim.push_back(rand256());
    thr = 1'b0;
    w0 = w_dat_q.size();
    pulse_start(27'h300, 64);
    t = 0;
    while (w_dat_q.size() < w0 + 10 && t < 200) begin @(negedge clock); t++; end
    chk("mid_reset_reached_beat10", w_dat_q.size() >= w0 + 10, 1'b1);
    #1 rst = 1'b1;
    #1 check_idle_outputs("mid_reset");
    repeat (3) @(posedge clock); #1;
    rst = 1'b0;
    aw0 = aw_addr_q.size(); w0 = w_dat_q.size();
    repeat (20) @(negedge clock);
    chk("post_reset_no_aw", aw_addr_q.size(), aw0);
    chk("post_reset_no_w", w_dat_q.size(), w0);
    chk("post_reset_busy", busy, 1'b0);
    run_frame(27'h500, 33, 1'b1, -1, 1'b0);

`ifdef WR_TIMEOUT_EN
    b_hold = 1'b1;
    run_frame(27'h800, 32, 1'b0, -1, 1'b1);
    chk("timeout_latency_ok", (done_cyc - last_wl_cyc >= 1020) && (done_cyc - last_wl_cyc <= 1030), 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
